wb_stage_ml: RTL

Multi-lane write-back stage for the LoongArch pipeline. Accepts a group of up to LANES retiring instructions from MEM and drives one register-file write port per lane, published to ID as the write/forward bus. Every retired lane is also serialised through a trace FIFO onto the single-write debug interface, one record per cycle, in program order. Back-pressure from that FIFO stalls MEM through wb_allow_in.

---
 rtl/wb_stage_ml.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wb_stage_ml.sv
// Multi-lane LoongArch write-back stage: per-lane RF write ports plus an in-order trace FIFO.
// Optional macro WB_TRACE_EN builds the trace FIFO and the debug interface; undefined ties them off.
module wb_stage_ml #(
  parameter int unsigned LANES       = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned TRACE_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  mem_to_wb_valid,
  input  logic [LANES-1:0]                      mem_lane_mask,
  input  logic [LANES*(1+ADDR_W+DATA_W+PC_W)-1:0] mem_to_wb_bus,
  output logic                                  wb_allow_in,
  output logic                                  wb_valid,
  output logic [LANES*(1+ADDR_W+DATA_W)-1:0]    wb_to_id_bus,
  output logic [PC_W-1:0]                       debug_wb_pc,
  output logic [3:0]                            debug_wb_rf_we,
  output logic [ADDR_W-1:0]                     debug_wb_rf_wnum,
  output logic [DATA_W-1:0]                     debug_wb_rf_wdata
);

  localparam int unsigned LW = 1 + ADDR_W + DATA_W + PC_W;
  localparam int unsigned TW = 1 + ADDR_W + DATA_W;

  logic [LANES*LW-1:0]             lane_bus_q;
  logic [LANES-1:0]                mask_q;
  logic [LANES-1:0]                lane_we;
  logic [LANES-1:0][ADDR_W-1:0]    lane_dest;
  logic [LANES-1:0][DATA_W-1:0]    lane_res;
  logic [LANES-1:0][PC_W-1:0]      lane_pc;
  logic [LANES-1:0]                kill;
  logic                            ready_go;
  logic                            retire;

  // Group register between MEM and WB
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_valid   <= 1'b0;
      mask_q     <= '0;
      lane_bus_q <= '0;
    end else if (wb_allow_in) begin
      wb_valid <= mem_to_wb_valid;
      if (mem_to_wb_valid) begin
        mask_q     <= mem_lane_mask;
        lane_bus_q <= mem_to_wb_bus;
      end
    end
  end

  // Unpack lanes: {gr_we, dest, result, pc}
  always_comb begin
    lane_we   = '0;
    lane_dest = '0;
    lane_res  = '0;
    lane_pc   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_pc[i]   = lane_bus_q[i*LW +: PC_W];
      lane_res[i]  = lane_bus_q[i*LW + PC_W +: DATA_W];
      lane_dest[i] = lane_bus_q[i*LW + PC_W + DATA_W +: ADDR_W];
      lane_we[i]   = lane_bus_q[i*LW + LW - 1];
    end
  end

  // An older lane loses its RF write to a younger same-group write of the same dest
  always_comb begin
    kill = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (mask_q[j] && lane_we[j] && (lane_dest[j] == lane_dest[i])) kill[i] = 1'b1;
      end
    end
  end

  assign retire      = wb_valid & ready_go & resetn;
  assign wb_allow_in = ~wb_valid | ready_go;

  always_comb begin
    wb_to_id_bus = '0;
    for (int i = 0; i < LANES; i++) begin
      wb_to_id_bus[i*TW +: TW] = {retire & mask_q[i] & lane_we[i] & ~kill[i], lane_dest[i], lane_res[i]};
    end
  end

`ifdef WB_TRACE_EN
  localparam int unsigned CNT_W = $clog2(TRACE_DEPTH + 1);
  localparam int unsigned CW1   = CNT_W + 1;
  localparam int unsigned PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int unsigned RW    = PC_W + 1 + ADDR_W + DATA_W;

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [RW-1:0]    fifo_mem [TRACE_DEPTH];
  logic [CNT_W-1:0] n_push;
  logic             pop;
  logic [PTR_W-1:0] slot [LANES];
  logic [RW-1:0]    head;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= TRACE_DEPTH) s = s - TRACE_DEPTH;
    return PTR_W'(s);
  endfunction

  always_comb begin
    n_push = '0;
    for (int i = 0; i < LANES; i++) n_push = n_push + CNT_W'(mask_q[i]);
  end

  assign pop      = (count != '0);
  assign ready_go = (CW1'(n_push) <= (CW1'(TRACE_DEPTH) - CW1'(count) + CW1'(pop)));
  assign head     = fifo_mem[rd_ptr];

  // Masked lanes take consecutive slots in ascending lane order
  always_comb begin
    int unsigned acc;
    acc = 0;
    for (int i = 0; i < LANES; i++) begin
      slot[i] = wrap_add(wr_ptr, acc);
      acc     = acc + 32'(mask_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count + (retire ? n_push : '0) - CNT_W'(pop);
      if (retire) wr_ptr <= wrap_add(wr_ptr, 32'(n_push));
      if (pop)    rd_ptr <= wrap_add(rd_ptr, 1);
    end
  end

  // Record layout {pc, we, dest, data}; killed lanes keep their original we
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (retire && mask_q[i]) fifo_mem[slot[i]] <= {lane_pc[i], lane_we[i], lane_dest[i], lane_res[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_we    <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else if (pop) begin
      debug_wb_pc       <= head[RW-1 -: PC_W];
      debug_wb_rf_we    <= {4{head[DATA_W + ADDR_W]}};
      debug_wb_rf_wnum  <= head[DATA_W +: ADDR_W];
      debug_wb_rf_wdata <= head[DATA_W-1:0];
    end else begin
      debug_wb_rf_we <= '0;
    end
  end
`else
  logic unused_trace_pc;

  assign ready_go          = 1'b1;
  assign unused_trace_pc   = ^lane_pc;
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_we    = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule
